// File: rtl/lbp_scan_ctrl_if.sv
// Handshake bundle between the LBP scan sequencer and its address generator / datapath.
interface lbp_scan_ctrl_if;
  logic        gray_ready;
  logic        initialize;
  logic        fill_right;
  logic        fill_left;
  logic        fill_down;
  logic        gray_addr_en;
  logic [3:0]  cycle;
  logic [13:0] lbp_addr;
  logic        gray_req;
  logic        lbp_valid;
  logic        finish;

  modport master (
    input  gray_ready,
    output initialize, fill_right, fill_left, fill_down, gray_addr_en,
    output cycle, lbp_addr, gray_req, lbp_valid, finish
  );

  modport slave (
    output gray_ready,
    input  initialize, fill_right, fill_left, fill_down, gray_addr_en,
    input  cycle, lbp_addr, gray_req, lbp_valid, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// Serpentine scan sequencer for the LBP engine: 3x3 init load, then one
// column/row refill per centre, with one LBP write strobe per centre.
module lbp_scan_ctrl #(
  parameter logic [6:0] ROW_LAST = 7'd126,
  parameter logic [6:0] COL_LAST = 7'd126
) (
  input  logic            clk,
  input  logic            reset,
  lbp_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, INIT, FILL, WAIT, CALC, DONE} state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN} dir_t;

  state_t     state_reg, state_next;
  dir_t       dir_reg, dir_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [6:0] row_reg, row_next;
  logic [6:0] col_reg, col_next;

  logic       initialize, fill_right, fill_left, fill_down;
  logic       gray_addr_en, gray_req, lbp_valid, finish;
  logic [3:0] cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      dir_reg   <= DIR_RIGHT;
      cnt_reg   <= 4'd0;
      row_reg   <= 7'd0;
      col_reg   <= 7'd0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    cnt_next     = cnt_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    initialize   = 1'b0;
    fill_right   = 1'b0;
    fill_left    = 1'b0;
    fill_down    = 1'b0;
    gray_addr_en = 1'b0;
    gray_req     = 1'b0;
    lbp_valid    = 1'b0;
    finish       = 1'b0;
    cycle        = 4'd0;

    unique case (state_reg)
      IDLE: begin
        if (bus.gray_ready) begin
          row_next   = 7'd1;
          col_next   = 7'd1;
          cnt_next   = 4'd1;
          state_next = INIT;
        end
      end
      INIT: begin
        initialize = 1'b1;
        gray_req   = 1'b1;
        cycle      = cnt_reg;
        if (cnt_reg == 4'd9) begin
          state_next = WAIT;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      WAIT: begin
        state_next = CALC;
      end
      CALC: begin
        // The centre moves now so lbp_addr already names the new centre during FILL.
        lbp_valid = 1'b1;
        cnt_next  = 4'd0;
        if (row_reg[0] && (col_reg < COL_LAST)) begin
          dir_next   = DIR_RIGHT;
          col_next   = col_reg + 7'd1;
          state_next = FILL;
        end else if (!row_reg[0] && (col_reg > 7'd1)) begin
          dir_next   = DIR_LEFT;
          col_next   = col_reg - 7'd1;
          state_next = FILL;
        end else if (row_reg < ROW_LAST) begin
          dir_next   = DIR_DOWN;
          row_next   = row_reg + 7'd1;
          state_next = FILL;
        end else begin
          state_next = DONE;
        end
      end
      FILL: begin
        fill_right   = (dir_reg == DIR_RIGHT);
        fill_left    = (dir_reg == DIR_LEFT);
        fill_down    = (dir_reg == DIR_DOWN);
        // Generator registers its address a clock after enable, so requests lag by one.
        gray_addr_en = (cnt_reg != 4'd3);
        gray_req     = (cnt_reg != 4'd0);
        cycle        = (cnt_reg == 4'd3) ? 4'd0 : cnt_reg;
        if (cnt_reg == 4'd3) begin
          state_next = WAIT;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        finish = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.initialize   = initialize;
  assign bus.fill_right   = fill_right;
  assign bus.fill_left    = fill_left;
  assign bus.fill_down    = fill_down;
  assign bus.gray_addr_en = gray_addr_en;
  assign bus.cycle        = cycle;
  assign bus.lbp_addr     = {row_reg, col_reg};
  assign bus.gray_req     = gray_req;
  assign bus.lbp_valid    = lbp_valid;
  assign bus.finish       = finish;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl on a 3x3 centre grid: per-cycle timeline model plus an address queue.
module tb_lbp_scan_ctrl;

  localparam logic [6:0] ROW_LAST = 7'd3;
  localparam logic [6:0] COL_LAST = 7'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_scan_ctrl_if bus ();

  lbp_scan_ctrl #(.ROW_LAST(ROW_LAST), .COL_LAST(COL_LAST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [13:0] seq[$];
  logic [13:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] observed();
    return {bus.initialize, bus.fill_right, bus.fill_left, bus.fill_down, bus.gray_addr_en,
            bus.cycle, bus.gray_req, bus.lbp_valid, bus.finish, bus.lbp_addr};
  endfunction

  // Expected outputs t clocks after the gray_ready sample edge.
  function automatic logic [25:0] model(input int t);
    logic ini, fr, fl, fd, en, req, val, fin;
    logic [3:0] cyc;
    logic [13:0] a, cur, nxt;
    int u, k, r, p, n;
    n = seq.size();
    {ini, fr, fl, fd, en, req, val, fin} = 8'd0;
    cyc = 4'd0;
    a = seq[0];
    if (t < 9) begin
      ini = 1'b1;
      req = 1'b1;
      cyc = 4'(t + 1);
    end else if (t >= 10) begin
      u = t - 10;
      k = u / 6;
      r = u % 6;
      if ((k > n - 1) || (k == n - 1 && r != 0)) begin
        fin = 1'b1;
        a = seq[n-1];
      end else if (r == 0) begin
        val = 1'b1;
        a = seq[k];
      end else begin
        cur = seq[k];
        nxt = seq[k+1];
        a = nxt;
        if (r <= 4) begin
          p = r - 1;
          if (nxt[13:7] != cur[13:7]) fd = 1'b1;
          else if (nxt[6:0] > cur[6:0]) fr = 1'b1;
          else fl = 1'b1;
          en  = (p < 3);
          cyc = (p < 3) ? 4'(p) : 4'd0;
          req = (p >= 1);
        end
      end
    end
    return {ini, fr, fl, fd, en, cyc, req, val, fin, a};
  endfunction

  task automatic start_scan();
    @(negedge clk);
    reset = 1'b0;
    bus.gray_ready = 1'b1;
    foreach (seq[i]) exp_q.push_back(seq[i]);
    @(posedge clk);
  endtask

  task automatic run_model(input int ncyc);
    logic [13:0] e;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      check($sformatf("t%0d", t), 32'(observed()), 32'(model(t)));
      if (bus.lbp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("lbp_addr_t%0d", t), 32'(bus.lbp_addr), 32'(e));
        end
      end
      bus.gray_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    for (int r = 1; r <= int'(ROW_LAST); r++) begin
      if (r % 2 == 1) for (int c = 1; c <= int'(COL_LAST); c++) seq.push_back({7'(r), 7'(c)});
      else for (int c = int'(COL_LAST); c >= 1; c--) seq.push_back({7'(r), 7'(c)});
    end

    reset = 1'b1;
    bus.gray_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(observed()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.gray_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle", 32'(observed()), 32'd0);
    end

    // Full scan with gray_ready toggling throughout and well past finish.
    start_scan();
    run_model(80);
    check("drain_scan1", 32'(exp_q.size()), 32'd0);
    bus.gray_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("finish_sticky", 32'(observed()), 32'(model(80 + i)));
    end

    // Abort mid-FILL, then restart on reset release.
    reset = 1'b1;
    @(negedge clk);
    check("reset_from_done", 32'(observed()), 32'd0);
    reset = 1'b0;
    bus.gray_ready = 1'b0;
    start_scan();
    run_model(13);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_fill_1", 32'(observed()), 32'd0);
    @(negedge clk);
    check("reset_mid_fill_2", 32'(observed()), 32'd0);
    exp_q.delete();
    start_scan();
    run_model(70);
    check("drain_scan2", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lbp_scan_ctrl.md
Name: lbp_scan_ctrl

Overview:
- Sequencer for the LBP engine. Walks every interior pixel centre of the 128x128 gray image in serpentine order: row 1 left-to-right, row 2 right-to-left, and so on.
- Drives the gray address generator with initialize, fill_right, fill_down, fill_left, cycle, gray_addr_en and lbp_addr.
- Tells the downstream window/LBP datapath when gray data is being fetched (gray_req) and when a finished LBP value is to be written (lbp_valid).
- Sits directly upstream of the gray address generator.

Parameters:
- ROW_LAST, 7'd126, last centre row (first centre row is fixed at 1).
- COL_LAST, 7'd126, last centre column (first centre column is fixed at 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- gray_ready  input  1  image memory loaded; starts a scan when sampled high in IDLE.
- initialize  output  1  high only in INIT; address generator uses the combinational 3x3 init map.
- fill_right  output  1  current move adds the right column.
- fill_left  output  1  current move adds the left column.
- fill_down  output  1  current move adds the bottom row.
- gray_addr_en  output  1  address generator load enable.
- cycle  output  4  INIT: 1..9; FILL: 0..2; otherwise 0.
- lbp_addr  output  14  current centre {row[6:0], col[6:0]}.
- gray_req  output  1  gray_addr from the generator is valid this cycle; memory data returns next cycle.
- lbp_valid  output  1  one-cycle strobe; datapath writes LBP result at lbp_addr.
- finish  output  1  scan complete; sticky until reset.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0 on the first clock edge with reset high, including lbp_addr=0 and finish=0. Reset in any state aborts the scan; no lbp_valid is issued after it.
- States: IDLE, INIT, FILL, WAIT, CALC, DONE.
- IDLE: outputs 0. When gray_ready=1: lbp_addr<={7'd1,7'd1}, go to INIT with cycle=1. gray_ready is ignored in every other state.
- INIT: 9 clocks. initialize=1, gray_req=1, cycle steps 1..9 (one per clock). After cycle=9, go to WAIT.
- WAIT: 1 clock, all strobes 0. Lets the last returned data be captured. Then go to CALC.
- CALC: 1 clock, lbp_valid=1, lbp_addr = the centre being written. Next-move decision:
  - odd row, col<COL_LAST: move right, lbp_addr col+1.
  - even row, col>1: move left, lbp_addr col-1.
  - row<ROW_LAST at the row end: move down, lbp_addr row+1, col unchanged.
  - otherwise: go to DONE.
  - On a move, lbp_addr updates at the CALC->FILL edge, so it already holds the new centre throughout FILL.
- FILL: 4 clocks, phase p=0..3.
  - Exactly one direction flag high for all 4 clocks.
  - gray_addr_en=1 on p=0..2 with cycle=p; on p=3, gray_addr_en=0 and cycle=0.
  - gray_req=1 on p=1..3, because the generator registers its address one clock after enable.
  - Then go to WAIT.
- DONE: finish=1, all other strobes 0. Stays in DONE until reset.
- Flags are mutually exclusive. initialize is never high together with any fill flag.
- Latency:
  - gray_ready sample -> first lbp_valid: 11 clocks.
  - Each subsequent lbp_valid: 6 clocks later.
- Row/column counters are 7-bit and never wrap: the boundary checks above stop them at 1 and at ROW_LAST/COL_LAST.
- Full-size scan: 126*126 = 15876 lbp_valid pulses. Last write at {126,1}=16129. finish rises 1 clock after the last lbp_valid.

Test Plan:
- Reset: hold reset 2 clocks mid-FILL -> next edge shows all outputs 0 and state IDLE; releasing with gray_ready=1 restarts at INIT with cycle=1 and lbp_addr=129.
- Init: gray_ready pulse -> 9 clocks of initialize=1, gray_req=1, cycle=1..9. Then 1 idle clock. Then lbp_valid with lbp_addr=129.
- Right move: after first CALC -> fill_right for 4 clocks, lbp_addr=130, gray_addr_en on cycle 0,1,2, gray_req on phases 1..3. lbp_valid 6 clocks after the previous one.
- Turns, ROW_LAST=3, COL_LAST=3:
  - at {1,3}=131 -> fill_down, lbp_addr=259 ({2,3}), then fill_left to 257.
  - at 257 -> fill_down to 385, then fill_right to 386 and 387.
- Finish, same params: exactly 9 lbp_valid pulses; order 129,130,131,259,258,257,385,386,387. finish high 1 clock after the pulse at 387, 60 clocks after gray_ready is sampled.
- Sticky/ignore: toggle gray_ready during the scan and after finish -> no effect; finish stays 1 until reset.
